uart_bridge: RTL and testbench

- Serial-to-bus initiator: receives command frames on a UART line and drives a memory-request port (valid/instr/addr/wdata/wstrb in, rdata/ready back).
- Acts as the host-side counterpart of the uart peripheral. Used as a debug/boot loader that writes program memory and reads back words over 8N1 serial.
- Contains its own bit-level receiver and transmitter plus a command parser FSM.

---
 rtl/uart_bridge_pkg.sv | 38 +++
 rtl/uart_bridge_phy.sv | 127 ++++++++++++
 rtl/uart_bridge.sv | 159 +++++++++++++++
 tb/tb_uart_bridge.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_bridge_pkg.sv
// Shared types and constants for the UART-to-memory bridge:
// parser/engine state encodings, protocol bytes, and the request register bundle.
package uart_bridge_pkg;

    typedef enum logic [2:0] {
        P_IDLE,
        P_ADDR,
        P_DATA,
        P_REQ,
        P_RESP
    } parser_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] RSP_ACK   = 8'h06;
    localparam logic [7:0] RSP_NAK   = 8'h15;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } mem_req_t;

endpackage

// File: rtl/uart_bridge_phy.sv
// 8N1 bit engine: 2-flop input synchronizer, centre-sampling receiver and transmitter.
// The last stop-bit cycle counts as idle so a queued byte follows with no gap.
module uart_bridge_phy
    import uart_bridge_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx,
    output logic       uart_tx,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       rx_err,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam logic [31:0] BIT_LAST  = 32'(CLKS_PER_BIT - 1);
    localparam logic [31:0] HALF_LAST = 32'(CLKS_PER_BIT / 2 - 1);

    logic        rx_meta, rx_sync;
    rx_state_t   rx_state, rx_state_nxt;
    logic [31:0] rx_cnt;
    logic [2:0]  rx_bit;
    logic [7:0]  rx_shift;

    tx_state_t   tx_state, tx_state_nxt;
    logic [31:0] tx_cnt;
    logic [2:0]  tx_bit;
    logic [7:0]  tx_shift;
    logic        tx_accept;

    assign rx_data = rx_shift;

    always_comb begin
        rx_state_nxt = rx_state;
        case (rx_state)
            RX_IDLE:  if (!rx_sync) rx_state_nxt = RX_START;
            RX_START: if (rx_cnt >= HALF_LAST) rx_state_nxt = rx_sync ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_cnt >= BIT_LAST && rx_bit == 3'd7) rx_state_nxt = RX_STOP;
            RX_STOP:  if (rx_cnt >= BIT_LAST) rx_state_nxt = RX_IDLE;
            default:  rx_state_nxt = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_meta  <= 1'b1;
            rx_sync  <= 1'b1;
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
        end else begin
            rx_meta  <= uart_rx;
            rx_sync  <= rx_meta;
            rx_state <= rx_state_nxt;
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
            if (rx_state != rx_state_nxt || rx_state == RX_IDLE)
                rx_cnt <= '0;
            else if (rx_cnt >= BIT_LAST)
                rx_cnt <= '0;
            else
                rx_cnt <= rx_cnt + 32'd1;
            if (rx_state == RX_DATA && rx_cnt >= BIT_LAST) begin
                rx_shift <= {rx_sync, rx_shift[7:1]};
                rx_bit   <= rx_bit + 3'd1;
            end
            if (rx_state == RX_STOP && rx_cnt >= BIT_LAST) begin
                rx_valid <= rx_sync;
                rx_err   <= !rx_sync;
            end
        end
    end

    assign tx_done   = (tx_state == TX_STOP) && (tx_cnt >= BIT_LAST);
    assign tx_busy   = (tx_state != TX_IDLE) && !tx_done;
    assign tx_accept = tx_start && !tx_busy;

    always_comb begin
        tx_state_nxt = tx_state;
        case (tx_state)
            TX_IDLE:  if (tx_accept) tx_state_nxt = TX_START;
            TX_START: if (tx_cnt >= BIT_LAST) tx_state_nxt = TX_DATA;
            TX_DATA:  if (tx_cnt >= BIT_LAST && tx_bit == 3'd7) tx_state_nxt = TX_STOP;
            TX_STOP:  if (tx_done) tx_state_nxt = tx_accept ? TX_START : TX_IDLE;
            default:  tx_state_nxt = TX_IDLE;
        endcase
    end

    always_comb begin
        uart_tx = 1'b1;
        case (tx_state)
            TX_START: uart_tx = 1'b0;
            TX_DATA:  uart_tx = tx_shift[0];
            default:  uart_tx = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
        end else begin
            tx_state <= tx_state_nxt;
            if (tx_state == TX_IDLE || tx_cnt >= BIT_LAST)
                tx_cnt <= '0;
            else
                tx_cnt <= tx_cnt + 32'd1;
            if (tx_accept)
                tx_shift <= tx_data;
            else if (tx_state == TX_DATA && tx_cnt >= BIT_LAST) begin
                tx_shift <= {1'b0, tx_shift[7:1]};
                tx_bit   <= tx_bit + 3'd1;
            end
        end
    end

endmodule

// File: rtl/uart_bridge.sv
// Serial command parser driving a single-outstanding memory request port.
// Frames: 'W' addr[4] data[4] -> ACK, 'R' addr[4] -> data[4]; other bytes -> NAK.
module uart_bridge
    import uart_bridge_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int TIMEOUT_CLKS = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic        mem_valid,
    output logic        mem_instr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CLKS - 1);

    parser_state_t state, state_nxt;
    mem_req_t      req;
    logic          op_write;
    logic [1:0]    byte_cnt;
    logic [2:0]    tx_idx;
    logic [2:0]    n_bytes;
    logic [31:0]   rdata_q;
    logic [31:0]   to_cnt;
    logic          timed_out;
    logic          is_cmd;

    logic          rx_valid, rx_err, tx_start, tx_busy, tx_done;
    logic [7:0]    rx_data, tx_data;

    uart_bridge_phy #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_phy (
        .clk      (clk),
        .rst      (rst),
        .uart_rx  (uart_rx),
        .uart_tx  (uart_tx),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_err   (rx_err),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done)
    );

    assign mem_instr = 1'b0;
    assign mem_addr  = req.addr;
    assign mem_wdata = req.wdata;
    assign mem_wstrb = req.wstrb;

    assign is_cmd    = (rx_data == CMD_WRITE) || (rx_data == CMD_READ);
    assign timed_out = (to_cnt >= TO_LAST);
    assign n_bytes   = op_write ? 3'd1 : 3'd4;

    always_comb begin
        state_nxt = state;
        tx_start  = 1'b0;
        tx_data   = RSP_NAK;
        case (state)
            P_IDLE: begin
                if (rx_valid) begin
                    if (is_cmd) state_nxt = P_ADDR;
                    else        tx_start  = 1'b1;
                end
            end
            P_ADDR: begin
                if (rx_err)
                    state_nxt = P_IDLE;
                else if (rx_valid) begin
                    if (byte_cnt == 2'd3) state_nxt = op_write ? P_DATA : P_REQ;
                end else if (timed_out)
                    state_nxt = P_IDLE;
            end
            P_DATA: begin
                if (rx_err)
                    state_nxt = P_IDLE;
                else if (rx_valid) begin
                    if (byte_cnt == 2'd3) state_nxt = P_REQ;
                end else if (timed_out)
                    state_nxt = P_IDLE;
            end
            P_REQ: begin
                if (mem_valid && mem_ready) state_nxt = P_RESP;
            end
            P_RESP: begin
                tx_data  = op_write ? RSP_ACK : rdata_q[{tx_idx[1:0], 3'b000} +: 8];
                tx_start = !tx_busy && (tx_idx < n_bytes);
                if (tx_done && tx_idx == n_bytes) state_nxt = P_IDLE;
            end
            default: state_nxt = P_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= P_IDLE;
            req       <= '0;
            op_write  <= 1'b0;
            byte_cnt  <= '0;
            tx_idx    <= '0;
            rdata_q   <= '0;
            to_cnt    <= '0;
            mem_valid <= 1'b0;
        end else begin
            state <= state_nxt;
            if ((state == P_ADDR || state == P_DATA) && !rx_valid)
                to_cnt <= to_cnt + 32'd1;
            else
                to_cnt <= '0;
            case (state)
                P_IDLE: begin
                    if (rx_valid && is_cmd) begin
                        op_write  <= (rx_data == CMD_WRITE);
                        req.addr  <= '0;
                        req.wdata <= '0;
                    end
                end
                P_ADDR: begin
                    if (rx_valid) begin
                        req.addr[{byte_cnt, 3'b000} +: 8] <= rx_data;
                        byte_cnt <= byte_cnt + 2'd1;
                    end
                end
                P_DATA: begin
                    if (rx_valid) begin
                        req.wdata[{byte_cnt, 3'b000} +: 8] <= rx_data;
                        byte_cnt <= byte_cnt + 2'd1;
                    end
                end
                P_REQ: begin
                    // ready is only honoured against our own outstanding request
                    if (mem_valid && mem_ready) begin
                        mem_valid <= 1'b0;
                        req.wstrb <= 4'h0;
                        rdata_q   <= mem_rdata;
                    end else
                        mem_valid <= 1'b1;
                end
                P_RESP: begin
                    if (tx_start) tx_idx <= tx_idx + 3'd1;
                end
                default: ;
            endcase
            if ((state_nxt == P_ADDR || state_nxt == P_DATA) && state_nxt != state)
                byte_cnt <= '0;
            if (state_nxt == P_REQ && state != P_REQ)
                req.wstrb <= op_write ? 4'hF : 4'h0;
            if (state_nxt == P_RESP && state != P_RESP)
                tx_idx <= '0;
        end
    end

endmodule

// File: tb/tb_uart_bridge.sv
// Scoreboard bench for uart_bridge: stimulus pushes expected requests/response bytes,
// a memory responder and a uart_tx frame monitor pop and compare independently.
module tb_uart_bridge;

    localparam int CPB = 8;
    localparam int TO  = 2000;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] rdata;
        bit          no_ready;
    } req_exp_t;

    typedef struct {
        logic [7:0] data;
        bit         follow;
    } tx_exp_t;

    typedef logic [7:0] byte_q_t[$];

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        uart_rx = 1'b1;
    logic        uart_tx;
    logic        mem_valid, mem_instr;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    int n_tests = 0;
    int n_fail  = 0;
    int valid_cycles = 0;

    req_exp_t req_q[$];
    tx_exp_t  tx_q[$];
    byte_q_t  bq;

    uart_bridge #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .uart_rx   (uart_rx),
        .uart_tx   (uart_tx),
        .mem_valid (mem_valid),
        .mem_instr (mem_instr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (mem_valid === 1'b1) valid_cycles++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = stop_bit;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
    endtask

    task automatic send_bytes(input byte_q_t q);
        foreach (q[i]) send_byte(q[i], 1'b1);
    endtask

    task automatic push_write(input logic [31:0] a, input logic [31:0] d, input bit no_rdy);
        req_q.push_back('{addr: a, wdata: d, wstrb: 4'hF, rdata: 32'h0, no_ready: no_rdy});
        if (!no_rdy) tx_q.push_back('{data: 8'h06, follow: 1'b0});
    endtask

    task automatic push_read(input logic [31:0] a, input logic [31:0] rd);
        req_q.push_back('{addr: a, wdata: 32'h0, wstrb: 4'h0, rdata: rd, no_ready: 1'b0});
        for (int i = 0; i < 4; i++)
            tx_q.push_back('{data: rd[8*i +: 8], follow: (i < 3)});
    endtask

    task automatic wait_drain(input string name, input int budget);
        int c = 0;
        while ((req_q.size() != 0 || tx_q.size() != 0) && c < budget) begin
            @(negedge clk);
            c++;
        end
        n_tests++;
        if (req_q.size() != 0 || tx_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: %0d requests and %0d tx bytes still pending, expected 0",
                     name, req_q.size(), tx_q.size());
            req_q.delete();
            tx_q.delete();
        end
        repeat (20) @(negedge clk);
    endtask

    // memory responder: pops one expected request per mem_valid rising
    initial begin : responder
        req_exp_t e;
        bit       stable;
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (mem_valid === 1'b1 && rst === 1'b1) begin
                if (req_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_req: got addr %h wstrb %h, expected no request",
                             mem_addr, mem_wstrb);
                    while (mem_valid === 1'b1) @(negedge clk);
                    continue;
                end
                e = req_q.pop_front();
                check("req_addr", mem_addr, e.addr);
                check("req_wstrb", {28'h0, mem_wstrb}, {28'h0, e.wstrb});
                if (e.wstrb == 4'hF) check("req_wdata", mem_wdata, e.wdata);
                if (e.no_ready) begin
                    while (mem_valid === 1'b1) @(negedge clk);
                    continue;
                end
                stable = 1'b1;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    if (mem_valid !== 1'b1 || mem_addr !== e.addr || mem_wstrb !== e.wstrb ||
                        (e.wstrb == 4'hF && mem_wdata !== e.wdata))
                        stable = 1'b0;
                end
                check("req_held", {31'h0, stable}, 32'h1);
                mem_rdata = e.rdata;
                mem_ready = 1'b1;
                @(negedge clk);
                mem_ready = 1'b0;
                mem_rdata = 32'h0;
                check("req_drop", {31'h0, mem_valid}, 32'h0);
            end
        end
    end

    // uart_tx monitor: captures full 80-cycle frames, checks bit widths and inter-frame gap
    initial begin : tx_mon
        logic    smp[80];
        logic [7:0] got;
        bit      uniform;
        bit      have_start = 1'b0;
        tx_exp_t e;
        forever begin
            if (!have_start) begin
                @(negedge clk);
                if (uart_tx !== 1'b0 || rst !== 1'b1) continue;
            end
            have_start = 1'b0;
            smp[0] = 1'b0;
            for (int k = 1; k < 80; k++) begin
                @(negedge clk);
                smp[k] = uart_tx;
            end
            uniform = 1'b1;
            for (int b = 0; b < 10; b++)
                for (int k = 1; k < 8; k++)
                    if (smp[b*8+k] !== smp[b*8]) uniform = 1'b0;
            for (int i = 0; i < 8; i++) got[i] = smp[(i+1)*8];
            if (tx_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL tx_unexpected: got byte %h, expected no frame", got);
                continue;
            end
            e = tx_q.pop_front();
            check("tx_byte", {24'h0, got}, {24'h0, e.data});
            check("tx_frame_shape", {30'h0, uniform, smp[72]}, 32'h3);
            if (e.follow) begin
                @(negedge clk);
                check("tx_no_gap", {31'h0, uart_tx}, 32'h0);
                have_start = (uart_tx === 1'b0);
            end
        end
    end

    initial begin : watchdog
        #(200000 * 10);
        $display("FAIL watchdog: simulation still running at time limit, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int lows;
        int v0;
        int c;

        repeat (4) @(negedge clk);
        check("rst_uart_tx", {31'h0, uart_tx}, 32'h1);
        check("rst_mem_valid", {31'h0, mem_valid}, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_mem_wstrb", {28'h0, mem_wstrb}, 32'h0);
        check("rst_mem_instr", {31'h0, mem_instr}, 32'h0);
        rst = 1'b1;
        repeat (10) @(negedge clk);

        // write
        push_write(32'h8000_0010, 32'hDEAD_BEEF, 1'b0);
        bq = '{8'h57, 8'h10, 8'h00, 8'h00, 8'h80, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        send_bytes(bq);
        wait_drain("write", 2000);

        // read
        push_read(32'h0000_0004, 32'h1234_5678);
        bq = '{8'h52, 8'h04, 8'h00, 8'h00, 8'h00};
        send_bytes(bq);
        wait_drain("read", 2000);

        // unknown command
        v0 = valid_cycles;
        tx_q.push_back('{data: 8'h15, follow: 1'b0});
        send_byte(8'h41, 1'b1);
        wait_drain("nak", 1000);
        check("nak_no_valid", valid_cycles - v0, 32'h0);

        // framing error aborts the write, following read runs normally
        v0 = valid_cycles;
        send_byte(8'h57, 1'b1);
        send_byte(8'h11, 1'b0);
        repeat (4 * CPB) @(negedge clk);
        check("frame_err_no_valid", valid_cycles - v0, 32'h0);
        push_read(32'h0000_000C, 32'hA5A5_0F0F);
        bq = '{8'h52, 8'h0C, 8'h00, 8'h00, 8'h00};
        send_bytes(bq);
        wait_drain("frame_err", 2000);

        // timeout mid-address, then a fresh read must parse from IDLE
        v0 = valid_cycles;
        bq = '{8'h57, 8'h11, 8'h22};
        send_bytes(bq);
        repeat (TO + 100) @(negedge clk);
        check("timeout_no_valid", valid_cycles - v0, 32'h0);
        push_read(32'h0000_0008, 32'h0BAD_C0DE);
        bq = '{8'h52, 8'h08, 8'h00, 8'h00, 8'h00};
        send_bytes(bq);
        wait_drain("timeout", 2000);

        // 2-cycle glitch must not be taken as a start bit
        uart_rx = 1'b0;
        repeat (2) @(negedge clk);
        uart_rx = 1'b1;
        lows = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (uart_tx === 1'b0) lows++;
        end
        check("glitch_quiet", lows, 32'h0);

        // reset while the request is outstanding
        push_write(32'h0000_0020, 32'h55AA_55AA, 1'b1);
        bq = '{8'h57, 8'h20, 8'h00, 8'h00, 8'h00, 8'hAA, 8'h55, 8'hAA, 8'h55};
        send_bytes(bq);
        c = 0;
        while (mem_valid !== 1'b1 && c < 200) begin
            @(negedge clk);
            c++;
        end
        check("reset_req_seen", {31'h0, mem_valid}, 32'h1);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_req_mem_valid", {31'h0, mem_valid}, 32'h0);
        check("rst_req_uart_tx", {31'h0, uart_tx}, 32'h1);
        check("rst_req_mem_addr", mem_addr, 32'h0);
        check("rst_req_mem_wdata", mem_wdata, 32'h0);
        check("rst_req_mem_wstrb", {28'h0, mem_wstrb}, 32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        wait_drain("reset", 100);

        // recovery after reset
        push_read(32'h0000_0100, 32'hCAFE_F00D);
        bq = '{8'h52, 8'h00, 8'h01, 8'h00, 8'h00};
        send_bytes(bq);
        wait_drain("post_reset", 2000);

        repeat (200) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
